// File: rtl/lapido_pkg.sv
// Shared definitions for the Lapido decode stage: opcodes, instruction field
// positions, register-file geometry and the decoded control bundle.
package lapido_pkg;

  localparam int NREG = 16;
  localparam int DW   = 32;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_ADDI = 8'h05;
  localparam logic [7:0] OP_LW   = 8'h10;
  localparam logic [7:0] OP_SW   = 8'h11;
  localparam logic [7:0] OP_BEQ  = 8'h20;
  localparam logic [7:0] OP_JMP  = 8'h21;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 20;
  localparam int RA_MSB  = 19;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_imm;
    logic illegal;
    logic uses_ra;
    logic uses_rb;
    logic is_halt;
  } ctl_t;

  // Unknown opcodes decode to an all-zero NOP bundle with only illegal set.
  function automatic ctl_t decode_op(input logic [7:0] op);
    ctl_t c;
    c = '0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.reg_write = 1'b1;
        c.uses_ra   = 1'b1;
        c.uses_rb   = 1'b1;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.uses_ra   = 1'b1;
        c.alu_imm   = 1'b1;
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.uses_ra   = 1'b1;
        c.alu_imm   = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.uses_ra   = 1'b1;
        c.uses_rb   = 1'b1;
        c.alu_imm   = 1'b1;
      end
      OP_BEQ: begin
        c.branch  = 1'b1;
        c.uses_ra = 1'b1;
        c.uses_rb = 1'b1;
      end
      OP_JMP:  c.jump    = 1'b1;
      OP_HALT: c.is_halt = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [DW-1:0] sext_imm(input logic [IMM_MSB:IMM_LSB] imm);
    return {{(DW-12){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between if_id, the register file, writeback, EX and the decode stage.
// Perf counter outputs exist only when ID_PERF_CNT_EN is defined.
interface id_stage_if;
  import lapido_pkg::*;

  logic          in_valid;
  logic [DW-1:0] in_pcpp;
  logic [DW-1:0] in_instr;
  logic [3:0]    rf_addr_a;
  logic [3:0]    rf_addr_b;
  logic [DW-1:0] rf_data_a;
  logic [DW-1:0] rf_data_b;
  logic          wb_we;
  logic [3:0]    wb_rd;
  logic          flush;
  logic          stall_if;
  logic          out_valid;
  logic [DW-1:0] out_pcpp;
  logic [DW-1:0] out_data_a;
  logic [DW-1:0] out_data_b;
  logic [DW-1:0] out_imm;
  logic [7:0]    out_opcode;
  logic [3:0]    out_rd;
  logic [3:0]    out_ra;
  logic [3:0]    out_rb;
  logic          out_reg_write;
  logic          out_mem_read;
  logic          out_mem_write;
  logic          out_branch;
  logic          out_jump;
  logic          out_alu_imm;
  logic          out_illegal;
  logic          halted;
`ifdef ID_PERF_CNT_EN
  logic [31:0]   perf_issued;
  logic [31:0]   perf_stalls;
`endif

  modport slave (
    input  in_valid, in_pcpp, in_instr, rf_data_a, rf_data_b, wb_we, wb_rd, flush,
    output rf_addr_a, rf_addr_b, stall_if, out_valid, out_pcpp, out_data_a, out_data_b,
           out_imm, out_opcode, out_rd, out_ra, out_rb, out_reg_write, out_mem_read,
           out_mem_write, out_branch, out_jump, out_alu_imm, out_illegal, halted
`ifdef ID_PERF_CNT_EN
    , output perf_issued, perf_stalls
`endif
  );

  modport master (
    output in_valid, in_pcpp, in_instr, rf_data_a, rf_data_b, wb_we, wb_rd, flush,
    input  rf_addr_a, rf_addr_b, stall_if, out_valid, out_pcpp, out_data_a, out_data_b,
           out_imm, out_opcode, out_rd, out_ra, out_rb, out_reg_write, out_mem_read,
           out_mem_write, out_branch, out_jump, out_alu_imm, out_illegal, halted
`ifdef ID_PERF_CNT_EN
    , input perf_issued, perf_stalls
`endif
  );

endinterface

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with
// flush-clear over issue-set over writeback-clear priority and a hazard query.
module id_scoreboard #(
  parameter  int NREG = 16,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_set,
  input  logic [IW-1:0] i_set_idx,
  input  logic          i_clr,
  input  logic [IW-1:0] i_clr_idx,
  input  logic          i_fclr,
  input  logic [IW-1:0] i_fclr_idx,
  input  logic [IW-1:0] i_ra,
  input  logic [IW-1:0] i_rb,
  input  logic [IW-1:0] i_rd,
  input  logic          i_uses_ra,
  input  logic          i_uses_rb,
  input  logic          i_writes_rd,
  output logic          o_hazard
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  // Later assignments win: a squashed ID/EX writer must never stay pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr)  w_pend_nxt[i_clr_idx]  = 1'b0;
    if (i_set)  w_pend_nxt[i_set_idx]  = 1'b1;
    if (i_fclr) w_pend_nxt[i_fclr_idx] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_nxt;
  end

  assign o_hazard = (r_pend[i_ra] & i_uses_ra) |
                    (r_pend[i_rb] & i_uses_rb) |
                    (r_pend[i_rd] & i_writes_rd);

endmodule

// File: rtl/id_stage.sv
// Lapido decode stage: field decode, register read, ID/EX register, hazard stall and HALT.
// Optional issue/stall counters are built when ID_PERF_CNT_EN is defined.
//
// state  | meaning
// S_RUN  | accepting instructions from if_id
// S_HALT | HALT has issued; IF held and no issue until reset
module id_stage
  import lapido_pkg::*;
(
  input logic          clock,
  input logic          reset,
  id_stage_if.slave    id_bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]    r_state;
  ctl_t          w_ctl;
  logic [7:0]    w_op;
  logic [3:0]    w_rd;
  logic [3:0]    w_ra;
  logic [3:0]    w_rb;
  logic          w_run;
  logic          w_hazard;
  logic          w_accept;
  logic          w_fclr;

  logic          r_valid;
  logic [DW-1:0] r_pcpp;
  logic [DW-1:0] r_data_a;
  logic [DW-1:0] r_data_b;
  logic [DW-1:0] r_imm;
  logic [7:0]    r_opcode;
  logic [3:0]    r_rd;
  logic [3:0]    r_ra;
  logic [3:0]    r_rb;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_branch;
  logic          r_jump;
  logic          r_alu_imm;
  logic          r_illegal;

  assign w_op  = id_bus.in_instr[OP_MSB:OP_LSB];
  assign w_rd  = id_bus.in_instr[RD_MSB:RD_LSB];
  assign w_ra  = id_bus.in_instr[RA_MSB:RA_LSB];
  assign w_rb  = id_bus.in_instr[RB_MSB:RB_LSB];
  assign w_ctl = decode_op(w_op);

  assign id_bus.rf_addr_a = w_ra;
  assign id_bus.rf_addr_b = w_rb;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = id_bus.in_valid & w_run & ~id_bus.flush & ~w_hazard;
  assign w_fclr   = id_bus.flush & r_valid & r_reg_write;

  // HALT holds IF unconditionally; in RUN a flush always releases the stall.
  assign id_bus.stall_if = ~w_run | (id_bus.in_valid & ~id_bus.flush & w_hazard);

  id_scoreboard #(.NREG(NREG)) u_sb (
    .clock       (clock),
    .reset       (reset),
    .i_set       (w_accept & w_ctl.reg_write),
    .i_set_idx   (w_rd),
    .i_clr       (id_bus.wb_we),
    .i_clr_idx   (id_bus.wb_rd),
    .i_fclr      (w_fclr),
    .i_fclr_idx  (r_rd),
    .i_ra        (w_ra),
    .i_rb        (w_rb),
    .i_rd        (w_rd),
    .i_uses_ra   (w_ctl.uses_ra),
    .i_uses_rb   (w_ctl.uses_rb),
    .i_writes_rd (w_ctl.reg_write),
    .o_hazard    (w_hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RUN;
    end else if (w_accept && w_ctl.is_halt) begin
      r_state <= S_HALT;
    end
  end

  // Bubbles clear the control bits so nothing downstream acts on stale decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pcpp      <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_imm       <= '0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_alu_imm   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pcpp      <= id_bus.in_pcpp;
        r_data_a    <= id_bus.rf_data_a;
        r_data_b    <= id_bus.rf_data_b;
        r_imm       <= sext_imm(id_bus.in_instr[IMM_MSB:IMM_LSB]);
        r_opcode    <= w_op;
        r_rd        <= w_rd;
        r_ra        <= w_ra;
        r_rb        <= w_rb;
        r_reg_write <= w_ctl.reg_write;
        r_mem_read  <= w_ctl.mem_read;
        r_mem_write <= w_ctl.mem_write;
        r_branch    <= w_ctl.branch;
        r_jump      <= w_ctl.jump;
        r_alu_imm   <= w_ctl.alu_imm;
        r_illegal   <= w_ctl.illegal;
      end else begin
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_branch    <= 1'b0;
        r_jump      <= 1'b0;
        r_alu_imm   <= 1'b0;
        r_illegal   <= 1'b0;
      end
    end
  end

  assign id_bus.out_valid     = r_valid;
  assign id_bus.out_pcpp      = r_pcpp;
  assign id_bus.out_data_a    = r_data_a;
  assign id_bus.out_data_b    = r_data_b;
  assign id_bus.out_imm       = r_imm;
  assign id_bus.out_opcode    = r_opcode;
  assign id_bus.out_rd        = r_rd;
  assign id_bus.out_ra        = r_ra;
  assign id_bus.out_rb        = r_rb;
  assign id_bus.out_reg_write = r_reg_write;
  assign id_bus.out_mem_read  = r_mem_read;
  assign id_bus.out_mem_write = r_mem_write;
  assign id_bus.out_branch    = r_branch;
  assign id_bus.out_jump      = r_jump;
  assign id_bus.out_alu_imm   = r_alu_imm;
  assign id_bus.out_illegal   = r_illegal;
  assign id_bus.halted        = (r_state == S_HALT);

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_issued <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_accept)                 r_perf_issued <= r_perf_issued + 32'd1;
      if (w_run && id_bus.stall_if) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign id_bus.perf_issued = r_perf_issued;
  assign id_bus.perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against a set-membership reference model of decode rules.
module tb_id_stage;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  id_stage_if bus ();
  id_stage dut (.clock(clock), .reset(reset), .id_bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  bit [15:0]   m_pend;
  bit          m_halt;
  bit          m_valid;
  bit [7:0]    m_op;
  bit [3:0]    m_rd, m_ra, m_rb;
  bit [31:0]   m_pcpp, m_da, m_db, m_imm;
  bit [6:0]    m_flags;
  bit          m_rw;
  int unsigned m_issued, m_stalls;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input bit [7:0] op, output bit rw, output bit ura,
                                     output bit urb, output bit [6:0] flags, output bit hlt);
    bit mr, mw, br, jp, ai, ill;
    rw  = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10};
    ura = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h20};
    urb = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h20};
    mr  = (op == 8'h10);
    mw  = (op == 8'h11);
    br  = (op == 8'h20);
    jp  = (op == 8'h21);
    ai  = op inside {8'h05, 8'h10, 8'h11};
    hlt = (op == 8'hFF);
    ill = !(op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                       8'h10, 8'h11, 8'h20, 8'h21, 8'hFF});
    flags = {rw, mr, mw, br, jp, ai, ill};
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_pcpp   = '0;
    bus.in_instr  = '0;
    bus.rf_data_a = '0;
    bus.rf_data_b = '0;
    bus.wb_we     = 1'b0;
    bus.wb_rd     = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive_idle();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    m_pend   = '0;
    m_halt   = 1'b0;
    m_valid  = 1'b0;
    m_rw     = 1'b0;
    m_issued = 0;
    m_stalls = 0;
    check("rst_pc_imm", 64'({bus.out_pcpp, bus.out_imm}), 64'd0);
    check("rst_data",   64'({bus.out_data_a, bus.out_data_b}), 64'd0);
    check("rst_ctl", 64'({bus.out_valid, bus.out_opcode, bus.out_rd, bus.out_ra, bus.out_rb,
                          bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_branch,
                          bus.out_jump, bus.out_alu_imm, bus.out_illegal}), 64'd0);
    check("rst_halt_stall", 64'({bus.halted, bus.stall_if}), 64'd0);
    check("rst_pend", 64'(dut.u_sb.r_pend), 64'd0);
`ifdef ID_PERF_CNT_EN
    check("rst_perf", 64'({bus.perf_issued, bus.perf_stalls}), 64'd0);
`endif
  endtask

  task automatic step(input bit v, input bit [31:0] instr, input bit we,
                      input bit [3:0] wrd, input bit fl);
    bit [7:0]  op;
    bit [3:0]  rd, ra, rb;
    bit        rw, ura, urb, hlt, haz, exp_stall, acc;
    bit [6:0]  flags;
    bit [31:0] pc, da, db;
    bit [15:0] np;
    int        s;
    @(negedge clock);
    pc = $urandom;
    da = $urandom;
    db = $urandom;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pcpp   = pc;
    bus.rf_data_a = da;
    bus.rf_data_b = db;
    bus.wb_we     = we;
    bus.wb_rd     = wrd;
    bus.flush     = fl;
    op = instr[31:24];
    rd = instr[23:20];
    ra = instr[19:16];
    rb = instr[15:12];
    ref_decode(op, rw, ura, urb, flags, hlt);
    haz = (ura && m_pend[ra]) || (urb && m_pend[rb]) || (rw && m_pend[rd]);
    exp_stall = m_halt || (v && !fl && haz);
    acc = v && !m_halt && !fl && !haz;
    #1;
    check("stall_if", 64'(bus.stall_if), 64'(exp_stall));
    check("rf_addr", 64'({bus.rf_addr_a, bus.rf_addr_b}), 64'({ra, rb}));
    if (!m_halt && exp_stall) m_stalls++;
    if (acc) m_issued++;
    np = m_pend;
    if (we) np[wrd] = 1'b0;
    if (acc && rw) np[rd] = 1'b1;
    if (fl && m_valid && m_rw) np[m_rd] = 1'b0;
    m_pend = np;
    if (acc && hlt) m_halt = 1'b1;
    m_valid = acc;
    if (acc) begin
      s = int'(instr[11:0]);
      if (s >= 2048) s = s - 4096;
      m_imm   = 32'(s);
      m_op    = op;
      m_rd    = rd;
      m_ra    = ra;
      m_rb    = rb;
      m_pcpp  = pc;
      m_da    = da;
      m_db    = db;
      m_flags = flags;
      m_rw    = rw;
    end
    @(posedge clock);
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_pc_imm", 64'({bus.out_pcpp, bus.out_imm}), 64'({m_pcpp, m_imm}));
      check("out_data", 64'({bus.out_data_a, bus.out_data_b}), 64'({m_da, m_db}));
      check("out_fields", 64'({bus.out_opcode, bus.out_rd, bus.out_ra, bus.out_rb,
                               bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
                               bus.out_branch, bus.out_jump, bus.out_alu_imm, bus.out_illegal}),
            64'({m_op, m_rd, m_ra, m_rb, m_flags}));
    end
    check("halted", 64'(bus.halted), 64'(m_halt));
    check("pend", 64'(dut.u_sb.r_pend), 64'(m_pend));
`ifdef ID_PERF_CNT_EN
    check("perf_issued", 64'(bus.perf_issued), 64'(m_issued));
    check("perf_stalls", 64'(bus.perf_stalls), 64'(m_stalls));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] ops [12];
    bit [7:0] op;
    int       halt_cycles;
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h20, 8'h21, 8'h7E, 8'h33};
    reset = 1'b1;
    drive_idle();
    do_reset();

    // ADD r1,r2,r3 issues and marks r1 pending
    step(1, 32'h01123000, 0, 4'd0, 0);
    check("t1_rd_rw", 64'({bus.out_valid, bus.out_rd, bus.out_reg_write}), 64'({1'b1, 4'd1, 1'b1}));
    check("t1_pend1", 64'(dut.u_sb.r_pend[1]), 64'd1);

    // SUB r4,r1,r5 waits for writeback of r1
    step(1, 32'h02415000, 0, 4'd0, 0);
    step(1, 32'h02415000, 0, 4'd0, 0);
    check("t2_stalled", 64'({bus.stall_if, bus.out_valid}), 64'({1'b1, 1'b0}));
    step(1, 32'h02415000, 1, 4'd1, 0);
    step(1, 32'h02415000, 0, 4'd0, 0);
    check("t2_sub_issued", 64'({bus.out_valid, bus.out_opcode, bus.out_rd}), 64'({1'b1, 8'h02, 4'd4}));

    // ADDI r2,r0,-1
    step(1, 32'h05200FFF, 0, 4'd0, 0);
    check("t3_imm", 64'(bus.out_imm), 64'(32'hFFFFFFFF));
    check("t3_alu_imm", 64'(bus.out_alu_imm), 64'd1);

    // LW r6 squashed by a flush; a reader of r6 then issues without stall
    step(1, 32'h10600000, 0, 4'd0, 0);
    step(1, 32'h01766000, 0, 4'd0, 1);
    check("t4_flushed", 64'({bus.out_valid, dut.u_sb.r_pend[6]}), 64'd0);
    step(1, 32'h01766000, 0, 4'd0, 0);
    check("t4_reader_issued", 64'({bus.out_valid, bus.out_rd}), 64'({1'b1, 4'd7}));

    // illegal opcode, then HALT
    step(1, 32'h7E000000, 0, 4'd0, 0);
    check("t5_illegal", 64'({bus.out_illegal, bus.out_reg_write}), 64'({1'b1, 1'b0}));
    step(1, 32'hFF000000, 0, 4'd0, 0);
    check("t5_halted", 64'(bus.halted), 64'd1);
    for (int i = 0; i < 3; i++) step(1, 32'h01800000, 0, 4'd0, 0);
    check("t5_halt_hold", 64'({bus.stall_if, bus.out_valid}), 64'({1'b1, 1'b0}));
    do_reset();

    // same-cycle writeback clear and issue set on r3: set wins
    step(1, 32'h05300001, 1, 4'd3, 0);
    check("t6_set_wins", 64'(dut.u_sb.r_pend[3]), 64'd1);

    // flush on the HALT accept cycle prevents halting
    step(1, 32'hFF000000, 0, 4'd0, 1);
    check("flush_halt", 64'(bus.halted), 64'd0);

    // flush-clear of the ID/EX writer beats a same-cycle writeback to another reg
    step(1, 32'h01500000, 0, 4'd0, 0);
    step(1, 32'h01800000, 1, 4'd3, 1);
    check("flush_clr", 64'({dut.u_sb.r_pend[5], dut.u_sb.r_pend[3]}), 64'd0);

    // reset in the middle of a stall
    step(1, 32'h01900000, 0, 4'd0, 0);
    step(1, 32'h01190000, 0, 4'd0, 0);
    check("mid_stall", 64'(bus.stall_if), 64'd1);
    do_reset();

    halt_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) op = 8'hFF;
      else op = ops[$urandom_range(0, 11)];
      step($urandom_range(0, 99) < 80,
           {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 12'($urandom)},
           $urandom_range(0, 99) < 30, 4'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 8);
      if (m_halt) halt_cycles++;
      if (halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
